uart_tx_controller: RTL and testbench

- Sequences transmit traffic from the MMIO UART data register (offset 0x000) into the byte-wide UART transmitter.
- Buffers MMIO writes in a small FIFO and splits 32-bit words into bytes, least-significant byte first.
- Issues one start pulse per byte and paces on the transmitter's active/done handshake.
- Reports busy, FIFO and error status back to the MMIO mapper for read-back.

---
 rtl/uart_tx_controller_if.sv | 55 +++++
 rtl/uart_tx_controller.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_controller_if.sv
// MMIO-side write/status signals and UART-side handshake for the transmit controller.
interface uart_tx_controller_if;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    logic              in_send_en;
    logic [DATA_W-1:0] in_send_data;
    logic              in_send_word;
    logic              in_clear_flags;
    logic              in_tx_active;
    logic              in_tx_done;
    logic              out_tx_start;
    logic [BYTE_W-1:0] out_tx_byte;
    logic              out_busy;
    logic              out_fifo_full;
    logic              out_fifo_empty;
    logic              out_overflow;
    logic              out_tx_error;

    // Driver side: MMIO mapper plus UART transmitter
    modport master (
        output in_send_en,
        output in_send_data,
        output in_send_word,
        output in_clear_flags,
        output in_tx_active,
        output in_tx_done,
        input  out_tx_start,
        input  out_tx_byte,
        input  out_busy,
        input  out_fifo_full,
        input  out_fifo_empty,
        input  out_overflow,
        input  out_tx_error
    );

    // Controller side
    modport slave (
        input  in_send_en,
        input  in_send_data,
        input  in_send_word,
        input  in_clear_flags,
        input  in_tx_active,
        input  in_tx_done,
        output out_tx_start,
        output out_tx_byte,
        output out_busy,
        output out_fifo_full,
        output out_fifo_empty,
        output out_overflow,
        output out_tx_error
    );

endinterface

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: queues MMIO writes, splits words LSB-first into bytes,
// issues one start pulse per byte and paces on the transmitter's active/done handshake.
module uart_tx_controller #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input logic                 in_clk,
    input logic                 in_reset,
    uart_tx_controller_if.slave bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned REM_W = 3;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic        word;
        logic [31:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    fifo_entry_t fifo_mem [FIFO_DEPTH];

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      shift_q, shift_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             overflow_q, overflow_d;
    logic             tx_error_q, tx_error_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             busy_q, busy_d;

    logic             push_c;
    logic             pop_c;
    logic             err_set_c;
    fifo_entry_t      head_c;
    fifo_entry_t      wr_entry_c;

    // Fullness is the registered value, so a write while full is dropped even if a pop happens too
    assign push_c     = bus.in_send_en && !full_q;
    assign head_c     = fifo_mem[rd_ptr_q];
    assign wr_entry_c = '{word: bus.in_send_word, data: bus.in_send_data};

    // FIFO storage; entries need no reset since occupancy gates every read
    always_ff @(posedge in_clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= wr_entry_c;
        end
    end

    // Next-state and byte sequencing
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        pop_c      = 1'b0;
        err_set_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    pop_c   = 1'b1;
                    shift_d = head_c.data;
                    rem_d   = head_c.word ? REM_W'(4) : REM_W'(1);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!bus.in_tx_active) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = shift_q[7:0];
                    tmo_d      = '0;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.in_tx_done) begin
                    if (rem_q > REM_W'(1)) begin
                        shift_d = {8'h00, shift_q[31:8]};
                        rem_d   = rem_q - REM_W'(1);
                        state_d = ST_START;
                    end else begin
                        rem_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_set_c = 1'b1;
                    rem_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping, status and sticky flags (a new event beats a same-cycle clear)
    always_comb begin
        wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        full_d     = (count_d == DEPTH_CNT);
        empty_d    = (count_d == '0);
        busy_d     = (state_d != ST_IDLE) || (count_d != '0);
        overflow_d = (overflow_q && !bus.in_clear_flags) || (bus.in_send_en && full_q);
        tx_error_d = (tx_error_q && !bus.in_clear_flags) || err_set_c;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            overflow_q <= 1'b0;
            tx_error_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
            tx_error_q <= tx_error_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.out_tx_start   = tx_start_q;
    assign bus.out_tx_byte    = tx_byte_q;
    assign bus.out_busy       = busy_q;
    assign bus.out_fifo_full  = full_q;
    assign bus.out_fifo_empty = empty_q;
    assign bus.out_overflow   = overflow_q;
    assign bus.out_tx_error   = tx_error_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    uart_tx_controller_if bus ();

    uart_tx_controller #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle outputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic w);
        bus.in_send_en   = 1'b1;
        bus.in_send_data = d;
        bus.in_send_word = w;
        tick();
        bus.in_send_en   = 1'b0;
    endtask

    // in_tx_done sampled on the n-th edge from now
    task automatic done_after(input int n);
        repeat (n - 1) tick();
        bus.in_tx_done = 1'b1;
        tick();
        bus.in_tx_done = 1'b0;
    endtask

    task automatic expect_start(input string tag, input logic [7:0] b, input int budget,
                                output int waited);
        waited = 0;
        while (bus.out_tx_start !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        chk({tag, "_start"}, 32'(bus.out_tx_start), 32'd1);
        chk({tag, "_byte"}, 32'(bus.out_tx_byte), 32'(b));
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (bus.out_tx_start === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_start"}, 32'(bus.out_tx_start), 32'd0);
        chk({tag, "_byte"}, 32'(bus.out_tx_byte), 32'd0);
        chk({tag, "_busy"}, 32'(bus.out_busy), 32'd0);
        chk({tag, "_empty"}, 32'(bus.out_fifo_empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.out_fifo_full), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'd0);
        chk({tag, "_err"}, 32'(bus.out_tx_error), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [7:0] wb [4];
        wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;

        bus.in_send_en     = 1'b0;
        bus.in_send_data   = '0;
        bus.in_send_word   = 1'b0;
        bus.in_clear_flags = 1'b0;
        bus.in_tx_active   = 1'b0;
        bus.in_tx_done     = 1'b0;

        // Reset values
        repeat (3) tick();
        chk_reset_state("rst");
        rst = 1'b0;

        // Single byte: push at N, pop at N+1, pulse after N+2
        push(32'h0000_00A5, 1'b0);
        chk("t1_empty_n", 32'(bus.out_fifo_empty), 32'd0);
        chk("t1_busy_n", 32'(bus.out_busy), 32'd1);
        chk("t1_start_n", 32'(bus.out_tx_start), 32'd0);
        tick();
        chk("t1_start_n1", 32'(bus.out_tx_start), 32'd0);
        chk("t1_empty_n1", 32'(bus.out_fifo_empty), 32'd1);
        tick();
        chk("t1_start_n2", 32'(bus.out_tx_start), 32'd1);
        chk("t1_byte", 32'(bus.out_tx_byte), 32'h0000_00A5);
        tick();
        chk("t1_one_cycle", 32'(bus.out_tx_start), 32'd0);
        chk("t1_byte_hold", 32'(bus.out_tx_byte), 32'h0000_00A5);
        chk("t1_busy_mid", 32'(bus.out_busy), 32'd1);
        done_after(9);
        chk("t1_busy_done", 32'(bus.out_busy), 32'd0);
        chk("t1_no_restart", 32'(bus.out_tx_start), 32'd0);

        // Full word, LSB first, done 8 cycles after each start
        push(32'h4433_2211, 1'b1);
        expect_start("t2_b0", wb[0], 4, w);
        chk("t2_latency", 32'(w), 32'd2);
        for (int k = 1; k < 4; k++) begin
            done_after(8);
            expect_start($sformatf("t2_b%0d", k), wb[k], 4, w);
            chk($sformatf("t2_gap%0d", k), 32'(w), 32'd1);
        end
        done_after(8);
        chk("t2_busy_end", 32'(bus.out_busy), 32'd0);

        // Overflow: one entry parked in START, then 5 writes into a 4-deep FIFO
        bus.in_tx_active = 1'b1;
        push(32'h0000_00B0, 1'b0);
        tick();
        chk("t3_parked_empty", 32'(bus.out_fifo_empty), 32'd1);
        chk("t3_parked_busy", 32'(bus.out_busy), 32'd1);
        chk("t3_parked_start", 32'(bus.out_tx_start), 32'd0);
        push(32'h0000_00B1, 1'b0);
        push(32'h0000_00B2, 1'b0);
        push(32'h0000_00B3, 1'b0);
        chk("t3_full_after3", 32'(bus.out_fifo_full), 32'd0);
        push(32'h0000_00B4, 1'b0);
        chk("t3_full_after4", 32'(bus.out_fifo_full), 32'd1);
        chk("t3_ovf_after4", 32'(bus.out_overflow), 32'd0);
        push(32'h0000_00B5, 1'b0);
        chk("t3_ovf_after5", 32'(bus.out_overflow), 32'd1);
        chk("t3_full_after5", 32'(bus.out_fifo_full), 32'd1);
        bus.in_tx_active = 1'b0;
        for (int k = 0; k < 5; k++) begin
            expect_start($sformatf("t3_e%0d", k), 8'(8'hB0 + k), 6, w);
            done_after(3);
        end
        quiet("t3_no_dropped_entry", 8);
        chk("t3_busy_end", 32'(bus.out_busy), 32'd0);
        chk("t3_empty_end", 32'(bus.out_fifo_empty), 32'd1);
        chk("t3_ovf_sticky", 32'(bus.out_overflow), 32'd1);
        bus.in_clear_flags = 1'b1;
        tick();
        bus.in_clear_flags = 1'b0;
        chk("t3_ovf_cleared", 32'(bus.out_overflow), 32'd0);

        // Busy gating: transmitter active for 20 cycles
        bus.in_tx_active = 1'b1;
        push(32'h0403_0201, 1'b1);
        quiet("t4_held", 19);
        chk("t4_before_release", 32'(bus.out_tx_start), 32'd0);
        bus.in_tx_active = 1'b0;
        tick();
        chk("t4_start_after_release", 32'(bus.out_tx_start), 32'd1);
        chk("t4_b0", 32'(bus.out_tx_byte), 32'h0000_0001);
        for (int k = 1; k < 4; k++) begin
            done_after(4);
            expect_start($sformatf("t4_b%0d", k), 8'(k + 1), 4, w);
        end
        done_after(4);
        chk("t4_busy_end", 32'(bus.out_busy), 32'd0);

        // Timeout on the first byte; next entry proceeds
        push(32'h8877_6655, 1'b1);
        push(32'h0000_0099, 1'b0);
        expect_start("t5_b0", 8'h55, 4, w);
        quiet("t5_no_pulse", 15);
        chk("t5_err_s15", 32'(bus.out_tx_error), 32'd0);
        tick();
        chk("t5_err_s16", 32'(bus.out_tx_error), 32'd1);
        chk("t5_start_s16", 32'(bus.out_tx_start), 32'd0);
        expect_start("t5_next", 8'h99, 4, w);
        chk("t5_next_wait", 32'(w), 32'd2);
        done_after(3);
        chk("t5_err_sticky", 32'(bus.out_tx_error), 32'd1);
        chk("t5_busy_end", 32'(bus.out_busy), 32'd0);
        bus.in_clear_flags = 1'b1;
        tick();
        bus.in_clear_flags = 1'b0;
        chk("t5_err_cleared", 32'(bus.out_tx_error), 32'd0);

        // Reset mid-word after the 2nd byte's start, with another entry queued
        push(32'hDEAD_BEEF, 1'b1);
        expect_start("t6_b0", 8'hEF, 4, w);
        done_after(3);
        push(32'h0000_0077, 1'b0);
        expect_start("t6_b1", 8'hBE, 4, w);
        chk("t6_b1_wait", 32'(w), 32'd0);
        chk("t6_queued", 32'(bus.out_fifo_empty), 32'd0);
        rst = 1'b1;
        tick();
        chk_reset_state("t6_rst");
        rst = 1'b0;
        bus.in_tx_done = 1'b1;
        tick();
        bus.in_tx_done = 1'b0;
        quiet("t6_late_done", 6);
        chk("t6_empty", 32'(bus.out_fifo_empty), 32'd1);
        chk("t6_busy", 32'(bus.out_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
